alu_wb_buffer: RTL and testbench
================================

ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 Parameter N, default 20: datapath width, equal to the ALU operand/result width.
REQ-002 Parameter RW, default 4: destination-register index width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port in_valid, input, 1: ALU result offered this cycle.
REQ-007 Port in_ready, output, 1: buffer can accept an entry.
REQ-008 Port in_result, input, N: ALU Result.
REQ-009 Port in_z, input, 1: ALU zero flag Z.
REQ-010 Port in_opcode, input, 3: ALU opcode of this result.
REQ-011 Port in_b, input, N: ALU operand B of this result.
REQ-012 Port in_rd, input, RW: destination register index.
REQ-013 Port out_valid, output, 1: head entry available.
REQ-014 Port out_ready, input, 1: register file accepts the head entry.
REQ-015 Port out_result, output, N; out_rd, output, RW; out_z, output, 1: head entry fields.
REQ-016 Port flag_z, output, 1: architectural zero flag for branches.
REQ-017 Port err, output, 1: sticky divide-by-zero error.
REQ-018 Port err_clr, input, 1: synchronous clear of err.
REQ-019 Port count, output, 2: occupancy, 0..2.

Function
REQ-020 The block SHALL be a 2-entry in-order FIFO of {result, rd, z}; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-021 in_ready SHALL be (count < 2) and SHALL NOT depend combinationally on out_ready.
REQ-022 out_valid SHALL be (count != 0); out_result, out_rd and out_z SHALL be driven to 0 while out_valid is 0.
REQ-023 Latency: an entry pushed at edge k SHALL be presented on the outputs from cycle k+1 when the FIFO was empty.
REQ-024 Push and pop on the same edge at count 1 SHALL leave count at 1, with the new entry becoming head.
REQ-025 At count 2, in_valid SHALL be ignored; at count 0, out_ready SHALL be ignored.
REQ-026 Read/write pointers SHALL be 1 bit each and wrap 1->0; entries SHALL leave in arrival order.
REQ-027 flag_z SHALL load the popped entry's z on every pop edge and hold otherwise.
REQ-028 in_opcode and in_b SHALL only affect behaviour through REQ-033.

Reset
REQ-029 While rst is 1, count, both pointers, flag_z and err SHALL be 0, in_ready SHALL be 1, and out_valid SHALL be 0, independent of clk.
REQ-030 Entries in flight when rst asserts SHALL be discarded; no pop SHALL be reported for them.
REQ-031 The first push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-032 Macro ALU_WB_DIV0_CHECK_EN SHALL compile divide-by-zero checking in or out.
REQ-033 With the macro defined, a push with in_opcode 3'b011 and in_b == 0 SHALL store result all-ones and z 0, and SHALL set err on that edge.
REQ-034 With the macro defined, err SHALL clear on an edge with err_clr 1; a set on the same edge SHALL win.
REQ-035 Without the macro, in_b and err_clr SHALL be ignored, err SHALL be constant 0, and results SHALL be stored unmodified.

Verification
REQ-036 Reset, then push result 0x00005 (rd 3, z 0) with out_ready 0 -> next cycle out_valid 1, out_result 0x00005, out_rd 3, count 1, flag_z 0.
REQ-037 Push 0x00001 then 0x00000 (z 1) with out_ready 0, then a third push -> count 2, in_ready 0, third entry dropped; pops return 0x00001 then 0x00000, and flag_z becomes 1 after the second pop.
REQ-038 At count 1, push 0x0000A while popping the head -> count stays 1, out_result 0x0000A on the next cycle.
REQ-039 Assert rst mid-cycle at count 2 -> count 0 and out_valid 0 immediately, before the next clk edge.
REQ-040 Macro defined: push opcode 3'b011 with in_b 0 -> stored result 0xFFFFF, err 1; push again with err_clr 1 -> err stays 1; err_clr 1 with no push -> err 0. Macro undefined: same stimulus -> result passes unchanged, err 0.

Source files
------------

// File: rtl/alu_wb_buffer.sv
// Two-entry in-order write-back buffer between the ALU and the register file.
// Optional divide-by-zero checking is compiled in with `define ALU_WB_DIV0_CHECK_EN.
module alu_wb_buffer #(
  parameter int N  = 20,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_result,
  input  logic          in_z,
  input  logic [2:0]    in_opcode,
  input  logic [N-1:0]  in_b,
  input  logic [RW-1:0] in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_z,
  output logic          flag_z,
  output logic          err,
  input  logic          err_clr,
  output logic [1:0]    count
);

  logic [N-1:0]  result_mem [2];
  logic [RW-1:0] rd_mem [2];
  logic [1:0]    z_mem;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;
  logic          push;
  logic          pop;
  logic [N-1:0]  store_result;
  logic          store_z;

  assign in_ready  = (cnt < 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt;

`ifdef ALU_WB_DIV0_CHECK_EN
  localparam logic [2:0] OP_DIV = 3'b011;

  function automatic logic is_div0(input logic [2:0] op, input logic [N-1:0] b);
    return (op == OP_DIV) && (b == '0);
  endfunction

  logic div0;
  assign div0         = is_div0(in_opcode, in_b);
  assign store_result = div0 ? '1 : in_result;
  assign store_z      = div0 ? 1'b0 : in_z;

  // A divide-by-zero push on the same edge as err_clr keeps err set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (push && div0) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg   = ^{in_opcode, in_b, err_clr};
  assign store_result = in_result;
  assign store_z      = in_z;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        flag_z <= z_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      result_mem[wr_ptr] <= store_result;
      rd_mem[wr_ptr]     <= in_rd;
      z_mem[wr_ptr]      <= store_z;
    end
  end

  assign out_result = out_valid ? result_mem[rd_ptr] : '0;
  assign out_rd     = out_valid ? rd_mem[rd_ptr]     : '0;
  assign out_z      = out_valid ? z_mem[rd_ptr]      : 1'b0;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Scoreboard bench for alu_wb_buffer: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_alu_wb_buffer;
  localparam int N  = 20;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_result;
  logic          in_z;
  logic [2:0]    in_opcode;
  logic [N-1:0]  in_b;
  logic [RW-1:0] in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_result;
  logic [RW-1:0] out_rd;
  logic          out_z;
  logic          flag_z;
  logic          err;
  logic          err_clr;
  logic [1:0]    count;

  alu_wb_buffer #(.N(N), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_z(in_z),
    .in_opcode(in_opcode), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_z(out_z), .flag_z(flag_z), .err(err),
    .err_clr(err_clr), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  r;
    logic [RW-1:0] rd;
    logic          z;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_cnt = 0;
  int   exp_cnt_now = 0;
  logic model_err = 1'b0;
  logic exp_err_now = 1'b0;
  logic last_z = 1'b0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of stimulus and advances the reference model to the next edge.
  task automatic drive(input logic v, input logic [N-1:0] res, input logic z,
                       input logic [RW-1:0] rd, input logic [2:0] op,
                       input logic [N-1:0] b, input logic ordy, input logic clr);
    logic acc_push, acc_pop, d0;
    ent_t e;
    in_valid = v; in_result = res; in_z = z; in_rd = rd;
    in_opcode = op; in_b = b; out_ready = ordy; err_clr = clr;
    exp_cnt_now = model_cnt;
    exp_err_now = model_err;
    acc_push = v && (model_cnt < 2);
    acc_pop  = ordy && (model_cnt > 0);
    d0 = 1'b0;
`ifdef ALU_WB_DIV0_CHECK_EN
    d0 = (op == 3'b011) && (b == 0);
`endif
    e.r  = d0 ? {N{1'b1}} : res;
    e.rd = rd;
    e.z  = d0 ? 1'b0 : z;
    if (acc_push) exp_q.push_back(e);
    model_cnt = model_cnt + int'(acc_push) - int'(acc_pop);
`ifdef ALU_WB_DIV0_CHECK_EN
    if (acc_push && d0) model_err = 1'b1;
    else if (clr) model_err = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, 1'b0, '0, 3'b000, '0, ordy, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    ent_t e;
    if (mon_en && !rst) begin
      check("count", 32'(count), 32'(exp_cnt_now));
      check("in_ready", 32'(in_ready), 32'(exp_cnt_now < 2));
      check("out_valid", 32'(out_valid), 32'(exp_cnt_now != 0));
      check("flag_z", 32'(flag_z), 32'(last_z));
      check("err", 32'(err), 32'(exp_err_now));
      if (exp_cnt_now != 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: got empty queue expected an entry at %0t", $time);
        end else begin
          e = exp_q[0];
          check("out_result", 32'(out_result), 32'(e.r));
          check("out_rd", 32'(out_rd), 32'(e.rd));
          check("out_z", 32'(out_z), 32'(e.z));
          if (out_ready) begin
            void'(exp_q.pop_front());
            last_z = e.z;
          end
        end
      end else begin
        check("idle_result", 32'(out_result), 32'd0);
        check("idle_rd", 32'(out_rd), 32'd0);
        check("idle_z", 32'(out_z), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_result = '0; in_z = 1'b0; in_opcode = 3'b000;
    in_b = '0; in_rd = '0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flag_z", 32'(flag_z), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // First push right after reset release, held without popping.
    drive(1'b1, 20'h00005, 1'b0, 4'd3, 3'b000, 20'h1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Fill to two, drop a third push, then drain in order.
    drive(1'b1, 20'h00001, 1'b0, 4'd1, 3'b000, 20'h1, 1'b0, 1'b0);
    drive(1'b1, 20'h00000, 1'b1, 4'd2, 3'b000, 20'h1, 1'b0, 1'b0);
    drive(1'b1, 20'h00077, 1'b0, 4'd7, 3'b000, 20'h1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Simultaneous push and pop at occupancy one.
    drive(1'b1, 20'h00009, 1'b0, 4'd4, 3'b000, 20'h1, 1'b0, 1'b0);
    drive(1'b1, 20'h0000A, 1'b0, 4'd5, 3'b000, 20'h1, 1'b1, 1'b0);
    idle(1'b0);

    // Reach occupancy two, then assert reset between clock edges.
    drive(1'b1, 20'h00011, 1'b1, 4'd6, 3'b000, 20'h1, 1'b0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd2);
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_flag_z", 32'(flag_z), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    model_cnt = 0; model_err = 1'b0; last_z = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Divide-by-zero substitution and err set/clear priority.
    drive(1'b1, 20'h00123, 1'b1, 4'd8, 3'b011, 20'h0, 1'b0, 1'b0);
    idle(1'b1);
    drive(1'b1, 20'h00456, 1'b1, 4'd9, 3'b011, 20'h0, 1'b1, 1'b1);
    idle(1'b1);
    drive(1'b0, 20'h0, 1'b0, 4'd0, 3'b000, 20'h0, 1'b1, 1'b1);
    idle(1'b1);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), N'($urandom), ($urandom_range(0, 3) == 0),
            RW'($urandom), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? '0 : N'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
    end
    repeat (4) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
